uart_transmit: RTL and testbench

- UART transmit serializer for the APB serial peripheral.
- Accepts an 8-bit byte on a start pulse and shifts out one 8N1 frame on a single line: start bit, 8 data bits LSB first, stop bit.
- Each bit lasts a fixed number of system clocks.
- Sits between the peripheral's register/FIFO logic and the TX pin; reports activity on `busy`.

---
 rtl/uart_transmit.sv | 143 ++++++++++++++
 tb/tb_uart_transmit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmit.sv
// rtl/uart_transmit.sv - 8N1 UART transmit serializer with registered line and busy outputs
//
// Ports:
//   clk        system clock, all state changes on its rising edge
//   n_rst      asynchronous active-low reset
//   data_in    byte to send, captured only on the accepting edge
//   tx_enable  start request, level-sampled while idle (or on the last stop-bit edge)
//   data_out   serial line, idles high
//   busy       high from the accepting edge until the frame's final edge

module uart_transmit #(
    parameter int BIT_PERIOD = 286
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] data_in,
    input  logic       tx_enable,
    output logic       data_out,
    output logic       busy
);

    localparam int CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             data_out_nxt;
    logic             busy_nxt;
    logic             bit_end;

    assign bit_end = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            data_out <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            shreg    <= shreg_nxt;
            data_out <= data_out_nxt;
            busy     <= busy_nxt;
        end
    end

    // Outputs are computed one cycle ahead so the line is a flop output and
    // changes exactly on the bit boundary edge.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        idx_nxt      = idx;
        shreg_nxt    = shreg;
        data_out_nxt = data_out;
        busy_nxt     = busy;

        case (state)
            IDLE: begin
                data_out_nxt = 1'b1;
                busy_nxt     = 1'b0;
                if (tx_enable) begin
                    state_nxt    = START;
                    shreg_nxt    = data_in;
                    cnt_nxt      = '0;
                    idx_nxt      = '0;
                    data_out_nxt = 1'b0;
                    busy_nxt     = 1'b1;
                end
            end

            START: begin
                if (bit_end) begin
                    state_nxt    = DATA;
                    cnt_nxt      = '0;
                    idx_nxt      = '0;
                    data_out_nxt = shreg[0];
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    shreg_nxt = {1'b0, shreg[7:1]};
                    if (idx == 3'd7) begin
                        state_nxt    = STOP;
                        data_out_nxt = 1'b1;
                    end else begin
                        idx_nxt      = idx + 3'd1;
                        // shreg[1] becomes bit 0 after this edge's shift
                        data_out_nxt = shreg[1];
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            STOP: begin
                if (bit_end) begin
                    cnt_nxt = '0;
                    idx_nxt = '0;
                    // The return-to-idle edge is also an accepting edge, so a
                    // held request chains frames with no idle gap.
                    if (tx_enable) begin
                        state_nxt    = START;
                        shreg_nxt    = data_in;
                        data_out_nxt = 1'b0;
                        busy_nxt     = 1'b1;
                    end else begin
                        state_nxt    = IDLE;
                        data_out_nxt = 1'b1;
                        busy_nxt     = 1'b0;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt    = IDLE;
                cnt_nxt      = '0;
                idx_nxt      = '0;
                data_out_nxt = 1'b1;
                busy_nxt     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_transmit.sv
// tb/tb_uart_transmit.sv - directed self-checking bench for uart_transmit

module tb_uart_transmit;

    localparam int BP = 286;
    localparam int FRAME = 10 * BP;

    logic       tb_clk;
    logic       n_rst;
    logic [7:0] data_in;
    logic       tx_enable;
    logic       data_out;
    logic       busy;

    int vec_cnt;
    int err_cnt;

    uart_transmit #(.BIT_PERIOD(BP)) dut (
        .clk       (tb_clk),
        .n_rst     (n_rst),
        .data_in   (data_in),
        .tx_enable (tx_enable),
        .data_out  (data_out),
        .busy      (busy)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // Called just after the accepting edge E. Samples each bit at its middle,
    // counts busy cycles over the 10-bit window and applies optional stimulus
    // at chosen cycles. Returns at the negedge of the last frame cycle.
    task automatic capture_frame(
        input  int          drop_cycle,
        input  int          pulse_cycle,
        input  logic [7:0]  pulse_data,
        input  int          chg_cycle,
        input  logic [7:0]  chg_data,
        output logic        first_busy,
        output logic        first_dout,
        output logic        start_bit,
        output logic [7:0]  data,
        output logic        stop_bit,
        output int          busy_cnt
    );
        busy_cnt   = 0;
        data       = 8'h00;
        start_bit  = 1'bx;
        stop_bit   = 1'bx;
        first_busy = 1'bx;
        first_dout = 1'bx;
        for (int t = 0; t < FRAME; t++) begin
            @(negedge tb_clk);
            if (t == 0) begin
                first_busy = busy;
                first_dout = data_out;
            end
            if (busy === 1'b1) busy_cnt++;
            if ((t % BP) == (BP / 2)) begin
                if (t / BP == 0)      start_bit = data_out;
                else if (t / BP == 9) stop_bit  = data_out;
                else                  data[t / BP - 1] = data_out;
            end
            if (t == drop_cycle) tx_enable = 1'b0;
            if (t == pulse_cycle) begin
                tx_enable = 1'b1;
                data_in   = pulse_data;
            end
            if (pulse_cycle >= 0 && t == pulse_cycle + 1) tx_enable = 1'b0;
            if (t == chg_cycle) data_in = chg_data;
            if (t != FRAME - 1) @(posedge tb_clk);
        end
    endtask

    logic       fb, fd, sb, pb;
    logic [7:0] rx;
    int         bc;

    task automatic check_frame(input string name, input logic [7:0] exp_byte);
        vec_cnt++;
        if (sb !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s start_bit: got %b expected 0", name, sb);
        end
        vec_cnt++;
        if (rx !== exp_byte) begin
            err_cnt++;
            $display("FAIL %s data: got %h expected %h", name, rx, exp_byte);
        end
        vec_cnt++;
        if (pb !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s stop_bit: got %b expected 1", name, pb);
        end
        vec_cnt++;
        if (bc !== FRAME) begin
            err_cnt++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, bc, FRAME);
        end
    endtask

    // Steps to the edge ending the frame and confirms the line returned to idle.
    task automatic check_frame_end(input string name);
        @(posedge tb_clk);
        @(negedge tb_clk);
        vec_cnt++;
        if (busy !== 1'b0 || data_out !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s end: busy=%b data_out=%b expected busy=0 data_out=1",
                     name, busy, data_out);
        end
    endtask

    task automatic check_idle(input string name, input int cycles);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge tb_clk);
            if (busy !== 1'b0 || data_out !== 1'b1) bad = 1'b1;
        end
        vec_cnt++;
        if (bad !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s idle: activity seen, expected line high and busy low", name);
        end
    endtask

    task automatic start_request(input logic [7:0] d);
        @(negedge tb_clk);
        tx_enable = 1'b1;
        data_in   = d;
        @(posedge tb_clk);
    endtask

    task automatic test_reset;
        n_rst     = 1'b0;
        tx_enable = 1'b0;
        data_in   = 8'h00;
        repeat (2) @(negedge tb_clk);
        vec_cnt++;
        if (data_out !== 1'b1 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_during: data_out=%b busy=%b expected 1/0", data_out, busy);
        end
        n_rst = 1'b1;
        check_idle("reset_after", 3 * BP);
    endtask

    task automatic test_single_frame;
        start_request(8'b10110101);
        capture_frame(1, -1, 8'h00, -1, 8'h00, fb, fd, sb, rx, pb, bc);
        vec_cnt++;
        if (fb !== 1'b1 || fd !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_accept: busy=%b data_out=%b expected 1/0", fb, fd);
        end
        check_frame("single", 8'b10110101);
    endtask

    task automatic test_back_to_back;
        check_frame_end("single");
        @(posedge tb_clk);
        start_request(8'b01000011);
        capture_frame(0, -1, 8'h00, -1, 8'h00, fb, fd, sb, rx, pb, bc);
        check_frame("back_to_back", 8'b01000011);
        check_frame_end("back_to_back");
    endtask

    task automatic test_hold_high;
        start_request(8'h5A);
        capture_frame(-1, -1, 8'h00, FRAME - 1, 8'hC3, fb, fd, sb, rx, pb, bc);
        check_frame("hold_first", 8'h5A);
        @(posedge tb_clk);
        capture_frame(0, -1, 8'h00, -1, 8'h00, fb, fd, sb, rx, pb, bc);
        vec_cnt++;
        if (fb !== 1'b1 || fd !== 1'b0) begin
            err_cnt++;
            $display("FAIL hold_restart: busy=%b data_out=%b expected 1/0", fb, fd);
        end
        check_frame("hold_second", 8'hC3);
        check_frame_end("hold_second");
    endtask

    task automatic test_request_during_busy;
        start_request(8'h3C);
        capture_frame(0, 4 * BP + 10, 8'hFF, -1, 8'h00, fb, fd, sb, rx, pb, bc);
        check_frame("busy_request", 8'h3C);
        check_frame_end("busy_request");
        check_idle("busy_request_no_extra", 2 * BP);
    endtask

    task automatic test_data_stability;
        start_request(8'hA5);
        capture_frame(0, -1, 8'h00, 0, 8'h00, fb, fd, sb, rx, pb, bc);
        check_frame("data_stable", 8'hA5);
        check_frame_end("data_stable");
    endtask

    task automatic test_reset_mid_frame;
        start_request(8'h96);
        @(negedge tb_clk);
        tx_enable = 1'b0;
        repeat (4 * BP + BP / 2 - 1) @(posedge tb_clk);
        @(negedge tb_clk);
        vec_cnt++;
        if (data_out !== 1'b0 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_bit3: data_out=%b busy=%b expected 0/1", data_out, busy);
        end
        #1 n_rst = 1'b0;
        #1;
        vec_cnt++;
        if (data_out !== 1'b1 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL mid_reset: data_out=%b busy=%b expected 1/0", data_out, busy);
        end
        repeat (2) @(negedge tb_clk);
        n_rst = 1'b1;
        check_idle("mid_reset_release", 3 * BP);
        start_request(8'hE1);
        capture_frame(0, -1, 8'h00, -1, 8'h00, fb, fd, sb, rx, pb, bc);
        check_frame("after_reset", 8'hE1);
        check_frame_end("after_reset");
    endtask

    initial begin
        vec_cnt   = 0;
        err_cnt   = 0;
        n_rst     = 1'b0;
        tx_enable = 1'b0;
        data_in   = 8'h00;
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_hold_high;
        test_request_during_busy;
        test_data_stability;
        test_reset_mid_frame;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
